// File: rtl/score_pkg.sv
// Shared types and helpers for the score display: BCD digit/score types and glyph geometry.
// Latency: n/a (types, constants and a combinational helper function only).
// Backpressure: none.
package score_pkg;

   localparam int GLYPH_W    = 4;
   localparam int GLYPH_H    = 8;
   localparam int NUM_DIGITS = 4;

   typedef logic [3:0] bcd_t;
   typedef bcd_t [3:0] score_t;   // [3] = thousands, [0] = units

   // Ripple-carry BCD increment that sticks at 9999 instead of wrapping.
   function automatic score_t bcd_inc(input score_t s);
      score_t r;
      logic   carry;
      r     = s;
      carry = 1'b1;
      if (s != 16'h9999) begin
         for (int i = 0; i < 4; i++) begin
            if (carry) begin
               if (s[i] == 4'd9) begin
                  r[i] = 4'd0;
               end else begin
                  r[i]  = s[i] + 4'd1;
                  carry = 1'b0;
               end
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Saturating 4-digit BCD score counter; clear beats tick when both pulse together.
// Latency: score_o reflects a tick/clear pulse on the clock edge that samples it.
// Backpressure: none; every pulse is consumed (ticks at 9999 are absorbed).
module bcd_score_counter
   import score_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   tick_i,
   input  logic   clear_i,
   output score_t score_o
);

   score_t score_q;
   score_t score_d;

   // Next score: clear has priority, otherwise saturating BCD increment on tick.
   always_comb begin
      score_d = score_q;
      if (clear_i) begin
         score_d = '0;
      end else if (tick_i) begin
         score_d = bcd_inc(score_q);
      end
   end

   // Score register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         score_q <= '0;
      end else begin
         score_q <= score_d;
      end
   end

   assign score_o = score_q;

endmodule

// File: rtl/score_digit_renderer.sv
// Draws the 4-digit score box on the raster using an external 1-cycle font ROM.
// Latency: pixel_on corresponds to the hcount/vcount presented 2 clocks earlier.
// Backpressure: none; one pixel per clock, streaming.
module score_digit_renderer
   import score_pkg::*;
#(
   parameter int X0         = 16,
   parameter int Y0         = 16,
   parameter int SCALE_LOG2 = 2,
   parameter int NUM_DIGITS = 4,
   parameter int DIGIT_GAP  = 1,
   parameter int BLANK_LZ   = 1,
   parameter int LATCH_LINE = 480
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [10:0] hcount,
   input  logic [9:0]  vcount,
   input  logic        score_tick,
   input  logic        score_clear,
   output logic [3:0]  rom_addr,
   input  logic [31:0] rom_data,
   output logic [15:0] score_bcd,
   output logic        pixel_on
);

   localparam int          CELL_W  = (GLYPH_W + DIGIT_GAP) << SCALE_LOG2;
   localparam int          BOX_H   = GLYPH_H << SCALE_LOG2;
   localparam logic [10:0] X0_L    = 11'(X0);
   localparam logic [11:0] X_END_L = 12'(X0 + NUM_DIGITS * CELL_W);
   localparam logic [9:0]  Y0_L    = 10'(Y0);
   localparam logic [10:0] Y_END_L = 11'(Y0 + BOX_H);
   localparam logic [10:0] CELL1   = 11'(CELL_W);
   localparam logic [10:0] CELL2   = 11'(2 * CELL_W);
   localparam logic [10:0] CELL3   = 11'(3 * CELL_W);
   localparam logic [9:0]  LATCH_L = 10'(LATCH_LINE);

   score_t      score_live;
   score_t      disp_q, disp_d;
   logic        in_box;
   logic [10:0] dx, cell_base, col_full;
   logic [9:0]  dy;
   logic [1:0]  idx;
   logic [2:0]  row;
   bcd_t        nib;
   logic        lead_zero, visible;
   logic [2:0]  row_q;
   logic [1:0]  col_q;
   logic        vis_q, pix_q;
   logic [4:0]  bit_sel;

   bcd_score_counter u_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick_i  (score_tick),
      .clear_i (score_clear),
      .score_o (score_live)
   );

   assign score_bcd = score_live;

   // Display copy only follows the live score once per frame, outside the visible area.
   always_comb begin
      disp_d = disp_q;
      if (hcount == 11'd0 && vcount == LATCH_L) begin
         disp_d = score_live;
      end
   end

   assign in_box = (hcount >= X0_L) && ({1'b0, hcount} < X_END_L) &&
                   (vcount >= Y0_L) && ({1'b0, vcount} < Y_END_L);
   assign dx  = hcount - X0_L;
   assign dy  = vcount - Y0_L;
   assign row = 3'(dy >> SCALE_LOG2);

   // Digit cell lookup by comparison against cell boundaries; index 0 is the thousands digit.
   always_comb begin
      idx       = 2'd3;
      cell_base = CELL3;
      if (dx < CELL1) begin
         idx       = 2'd0;
         cell_base = '0;
      end else if (dx < CELL2) begin
         idx       = 2'd1;
         cell_base = CELL1;
      end else if (dx < CELL3) begin
         idx       = 2'd2;
         cell_base = CELL2;
      end
   end

   assign col_full = (dx - cell_base) >> SCALE_LOG2;
   assign nib      = disp_q[2'd3 - idx];

   // A digit is a leading zero when it and every digit to its left are zero; units never blank.
   always_comb begin
      lead_zero = 1'b0;
      case (idx)
         2'd0:    lead_zero = (disp_q[3] == 4'd0);
         2'd1:    lead_zero = (disp_q[3:2] == '0);
         2'd2:    lead_zero = (disp_q[3:1] == '0);
         default: lead_zero = 1'b0;
      endcase
   end

   assign visible  = in_box && (col_full < 11'd4) && !((BLANK_LZ != 0) && lead_zero);
   assign rom_addr = in_box ? nib : 4'd0;
   assign bit_sel  = 5'd31 - {row_q, col_q};

   // Stage 1 lines up glyph coordinates with the ROM read; stage 2 picks the glyph bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_q <= '0;
         row_q  <= '0;
         col_q  <= '0;
         vis_q  <= 1'b0;
         pix_q  <= 1'b0;
      end else begin
         disp_q <= disp_d;
         row_q  <= row;
         col_q  <= col_full[1:0];
         vis_q  <= visible;
         pix_q  <= vis_q & rom_data[bit_sel];
      end
   end

   assign pixel_on = pix_q;

endmodule
